// File: rtl/rvfpm_pkg.sv
// Shared types for the rvfpm writeback path.
// Destination codes and the reorder-buffer entry layout.
package rvfpm_pkg;

    localparam int FLEN = 32;

    typedef enum logic [1:0] {
        DST_FREG = 2'd0,
        DST_XREG = 2'd1,
        DST_MEM  = 2'd2
    } dest_e;

    typedef struct packed {
        logic            valid;
        logic            done;
        dest_e           dest;
        logic [FLEN-1:0] data;
        logic [4:0]      fflags;
    } rob_entry_t;

endpackage

// File: rtl/rvfpm_wb_reorder.sv
// In-order retirement buffer between the rvfpm pipeline and the integer core.
// Results land out of order by ID and leave in issue order on Xreg/Mem channels.
module rvfpm_wb_reorder #(
    parameter int XLEN       = 32,
    parameter int FLEN       = 32,
    parameter int X_ID_WIDTH = 4,
    parameter int DEPTH      = 8
) (
    input  logic                    i_ck,
    input  logic                    i_rst_n,
    input  logic                    i_flush,
    input  logic                    i_issue_valid,
    input  logic [1:0]              i_issue_dest,
    output logic                    o_issue_ready,
    output logic [X_ID_WIDTH-1:0]   o_issue_id,
    input  logic                    i_res_valid,
    input  logic [X_ID_WIDTH-1:0]   i_res_id,
    input  logic [FLEN-1:0]         i_res_data,
    input  logic [4:0]              i_res_fflags,
    output logic                    o_toXreg_valid,
    input  logic                    i_toXreg_ready,
    output logic [XLEN-1:0]         o_data_toXreg,
    output logic                    o_toMem_valid,
    input  logic                    i_toMem_ready,
    output logic [FLEN-1:0]         o_data_toMem,
    output logic [X_ID_WIDTH-1:0]   o_id_out,
    output logic [4:0]              o_fflags_acc,
    input  logic                    i_fflags_clr,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_err_spurious
);
    import rvfpm_pkg::*;

    localparam int AW = $clog2(DEPTH);

    rob_entry_t r_rob [DEPTH];
    logic [AW:0] r_head;
    logic [AW:0] r_tail;
    logic [4:0]  r_fflags;
    logic        r_err;

    rob_entry_t    w_head;
    logic          w_head_rdy;
    logic          w_full;
    logic          w_issue;
    logic          w_retire;
    logic          w_auto;
    logic          w_res_ok;
    logic          w_res_inrange;
    logic [AW-1:0] w_res_idx;
    logic [AW-1:0] w_head_idx;
    logic [AW-1:0] w_tail_idx;

    assign w_head_idx = r_head[AW-1:0];
    assign w_tail_idx = r_tail[AW-1:0];
    assign w_full     = (w_head_idx == w_tail_idx) && (r_head[AW] != r_tail[AW]);
    assign w_issue    = i_issue_valid && !w_full && !i_flush;

    assign o_issue_ready = !w_full;
    assign o_issue_id    = X_ID_WIDTH'(w_tail_idx);
    assign o_count       = r_tail - r_head;

    // A result aimed at the retiring head fails here since that entry is done.
    assign w_res_idx     = i_res_id[AW-1:0];
    assign w_res_inrange = ({1'b0, i_res_id} < (X_ID_WIDTH+1)'(DEPTH));
    assign w_res_ok      = w_res_inrange && r_rob[w_res_idx].valid
                           && !r_rob[w_res_idx].done;

    always_comb begin
        w_head         = r_rob[w_head_idx];
        w_head_rdy     = w_head.valid && w_head.done;
        o_toXreg_valid = 1'b0;
        o_toMem_valid  = 1'b0;
        w_auto         = 1'b0;
        unique case (w_head.dest)
            DST_XREG: o_toXreg_valid = w_head_rdy;
            DST_MEM:  o_toMem_valid  = w_head_rdy;
            default:  w_auto         = w_head_rdy;
        endcase
        w_retire = (o_toXreg_valid && i_toXreg_ready)
                 || (o_toMem_valid && i_toMem_ready)
                 || w_auto;
    end

    always_comb begin
        o_data_toXreg = '0;
        o_data_toMem  = '0;
        o_id_out      = '0;
        if (o_toXreg_valid) begin
            o_data_toXreg = w_head.data[XLEN-1:0];
        end
        if (o_toMem_valid) begin
            o_data_toMem = w_head.data;
        end
        if (o_toXreg_valid || o_toMem_valid) begin
            o_id_out = X_ID_WIDTH'(w_head_idx);
        end
    end

    assign o_fflags_acc   = r_fflags;
    assign o_err_spurious = r_err;

    always_ff @(posedge i_ck or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rob[i] <= '0;
            end
            r_head   <= '0;
            r_tail   <= '0;
            r_fflags <= '0;
            r_err    <= 1'b0;
        end else begin
            // A handshake seen on the outputs counts even in a flush cycle.
            if (w_retire) begin
                r_fflags <= (i_fflags_clr ? 5'b0 : r_fflags) | w_head.fflags;
            end else if (i_fflags_clr) begin
                r_fflags <= 5'b0;
            end
            if (i_res_valid && !w_res_ok) begin
                r_err <= 1'b1;
            end
            if (i_flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_rob[i] <= '0;
                end
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_issue) begin
                    r_rob[w_tail_idx].valid  <= 1'b1;
                    r_rob[w_tail_idx].done   <= 1'b0;
                    r_rob[w_tail_idx].dest   <= dest_e'(i_issue_dest);
                    r_rob[w_tail_idx].data   <= '0;
                    r_rob[w_tail_idx].fflags <= '0;
                    r_tail <= r_tail + 1'b1;
                end
                if (i_res_valid && w_res_ok) begin
                    r_rob[w_res_idx].done   <= 1'b1;
                    r_rob[w_res_idx].data   <= i_res_data;
                    r_rob[w_res_idx].fflags <= i_res_fflags;
                end
                if (w_retire) begin
                    r_rob[w_head_idx] <= '0;
                    r_head <= r_head + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rvfpm_wb_reorder.sv
// Scoreboard bench for rvfpm_wb_reorder.
// Issue order is queued; each channel transfer pops and compares.
module tb_rvfpm_wb_reorder;
    import rvfpm_pkg::*;

    logic        i_ck = 1'b0;
    logic        i_rst_n;
    logic        i_flush;
    logic        i_issue_valid;
    logic [1:0]  i_issue_dest;
    logic        o_issue_ready;
    logic [3:0]  o_issue_id;
    logic        i_res_valid;
    logic [3:0]  i_res_id;
    logic [31:0] i_res_data;
    logic [4:0]  i_res_fflags;
    logic        o_toXreg_valid;
    logic        i_toXreg_ready;
    logic [31:0] o_data_toXreg;
    logic        o_toMem_valid;
    logic        i_toMem_ready;
    logic [31:0] o_data_toMem;
    logic [3:0]  o_id_out;
    logic [4:0]  o_fflags_acc;
    logic        i_fflags_clr;
    logic [3:0]  o_count;
    logic        o_err_spurious;

    rvfpm_wb_reorder dut (
        .i_ck(i_ck), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_issue_valid(i_issue_valid), .i_issue_dest(i_issue_dest),
        .o_issue_ready(o_issue_ready), .o_issue_id(o_issue_id),
        .i_res_valid(i_res_valid), .i_res_id(i_res_id),
        .i_res_data(i_res_data), .i_res_fflags(i_res_fflags),
        .o_toXreg_valid(o_toXreg_valid), .i_toXreg_ready(i_toXreg_ready),
        .o_data_toXreg(o_data_toXreg),
        .o_toMem_valid(o_toMem_valid), .i_toMem_ready(i_toMem_ready),
        .o_data_toMem(o_data_toMem), .o_id_out(o_id_out),
        .o_fflags_acc(o_fflags_acc), .i_fflags_clr(i_fflags_clr),
        .o_count(o_count), .o_err_spurious(o_err_spurious)
    );

    always #5 i_ck = ~i_ck;

    typedef struct {
        logic [1:0] dest;
        logic [3:0] id;
    } sb_t;

    sb_t         sb_q [$];
    logic [31:0] exp_data [16];
    int          n_vec = 0;
    int          n_err = 0;
    int          m_tail = 0;
    int          cyc = 0;
    int          ret_n = 0;
    int          ret_first = 0;
    int          ret_last = 0;

    always @(posedge i_ck) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mon_pop(input logic [1:0] ch, input logic [3:0] id,
                           input logic [31:0] d);
        sb_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk("ret_dest", ch, e.dest);
            chk("ret_id", id, e.id);
            chk("ret_data", d, exp_data[e.id]);
        end
        if (ret_n == 0) ret_first = cyc;
        ret_last = cyc;
        ret_n++;
    endtask

    always @(negedge i_ck) begin
        if (i_rst_n) begin
            if (o_toXreg_valid && o_toMem_valid)
                chk("both_valid", 1, 0);
            if (o_toXreg_valid && i_toXreg_ready)
                mon_pop(DST_XREG, o_id_out, o_data_toXreg);
            if (o_toMem_valid && i_toMem_ready)
                mon_pop(DST_MEM, o_id_out, o_data_toMem);
        end
    end

    task automatic tick();
        @(posedge i_ck);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_flush = 0; i_issue_valid = 0; i_issue_dest = 0;
        i_res_valid = 0; i_res_id = 0; i_res_data = 0; i_res_fflags = 0;
        i_toXreg_ready = 1; i_toMem_ready = 1; i_fflags_clr = 0;
        tick();
        tick();
        sb_q.delete();
        m_tail = 0;
        i_rst_n = 1'b1;
    endtask

    task automatic issue(input logic [1:0] d);
        sb_t e;
        i_issue_valid = 1'b1;
        i_issue_dest = d;
        chk("issue_ready", o_issue_ready, 1);
        chk("issue_id", o_issue_id, 4'(m_tail));
        if (d != DST_FREG) begin
            e.dest = d;
            e.id = 4'(m_tail);
            sb_q.push_back(e);
        end
        tick();
        i_issue_valid = 1'b0;
        m_tail = (m_tail + 1) % 8;
    endtask

    task automatic result(input logic [3:0] id, input logic [31:0] d,
                          input logic [4:0] ff, input bit legal);
        i_res_valid = 1'b1;
        i_res_id = id;
        i_res_data = d;
        i_res_fflags = ff;
        if (legal) exp_data[id] = d;
        tick();
        i_res_valid = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0;
        do_reset();
        i_rst_n = 1'b0;
        #1;
        chk("rst_ready", o_issue_ready, 1);
        chk("rst_count", o_count, 0);
        chk("rst_xv", o_toXreg_valid, 0);
        chk("rst_mv", o_toMem_valid, 0);
        chk("rst_ff", o_fflags_acc, 0);
        chk("rst_err", o_err_spurious, 0);
        chk("rst_xdata", o_data_toXreg, 0);
        i_rst_n = 1'b1;

        // 1: out-of-order completion, in-order retire
        issue(DST_XREG);
        issue(DST_MEM);
        chk("t1_count", o_count, 2);
        result(4'd1, 32'h3f800000, 5'b0, 1);
        chk("t1_hold", o_toMem_valid, 0);
        result(4'd0, 32'h412028f6, 5'b0, 1);
        chk("t1_xv", o_toXreg_valid, 1);
        chk("t1_xid", o_id_out, 0);
        tick();
        chk("t1_mv", o_toMem_valid, 1);
        chk("t1_mid", o_id_out, 1);
        tick();
        tick();
        chk("t1_empty", o_count, 0);

        // 2: fill, then drain back-to-back
        do_reset();
        i_toXreg_ready = 1'b0;
        for (int i = 0; i < 8; i++) issue(DST_XREG);
        chk("t2_full", o_issue_ready, 0);
        chk("t2_count8", o_count, 8);
        for (int i = 0; i < 8; i++)
            result(4'(i), 32'h1000 + i, 5'b0, 1);
        chk("t2_stall", o_count, 8);
        ret_n = 0;
        i_toXreg_ready = 1'b1;
        chk("t2_nobypass", o_issue_ready, 0);
        tick();
        chk("t2_ready_back", o_issue_ready, 1);
        repeat (8) tick();
        chk("t2_nret", ret_n, 8);
        chk("t2_consec", ret_last - ret_first, 7);
        chk("t2_drained", o_count, 0);

        // 3: Mem backpressure
        do_reset();
        i_toMem_ready = 1'b0;
        issue(DST_MEM);
        result(4'd0, 32'hdeadbeef, 5'b0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_mv", o_toMem_valid, 1);
            chk("t3_data", o_data_toMem, 32'hdeadbeef);
            chk("t3_id", o_id_out, 0);
            chk("t3_count", o_count, 1);
            tick();
        end
        i_toMem_ready = 1'b1;
        tick();
        chk("t3_done", o_count, 0);

        // 4: FREG auto retire and sticky fflags
        do_reset();
        issue(DST_FREG);
        issue(DST_XREG);
        result(4'd0, 32'h1, 5'b00001, 1);
        result(4'd1, 32'h2, 5'b10000, 1);
        repeat (3) tick();
        chk("t4_count", o_count, 0);
        chk("t4_ff", o_fflags_acc, 5'b10001);
        i_toXreg_ready = 1'b0;
        issue(DST_XREG);
        result(4'd2, 32'h3, 5'b00100, 1);
        i_toXreg_ready = 1'b1;
        i_fflags_clr = 1'b1;
        tick();
        i_fflags_clr = 1'b0;
        chk("t4_clr_ret", o_fflags_acc, 5'b00100);
        i_fflags_clr = 1'b1;
        tick();
        i_fflags_clr = 1'b0;
        chk("t4_clr", o_fflags_acc, 0);

        // 5: spurious results
        do_reset();
        result(4'd3, 32'h5, 5'b0, 0);
        chk("t5_err_unalloc", o_err_spurious, 1);
        chk("t5_nov", o_toXreg_valid | o_toMem_valid, 0);
        chk("t5_count", o_count, 0);
        do_reset();
        i_toXreg_ready = 1'b0;
        issue(DST_XREG);
        result(4'd0, 32'haaaa0000, 5'b0, 1);
        chk("t5_err_clean", o_err_spurious, 0);
        result(4'd0, 32'hbbbb0000, 5'b0, 0);
        chk("t5_err_dup", o_err_spurious, 1);
        chk("t5_keep", o_data_toXreg, 32'haaaa0000);
        chk("t5_count1", o_count, 1);

        // 6: flush, late result, async reset mid-handshake
        do_reset();
        for (int i = 0; i < 4; i++) issue(DST_XREG);
        i_flush = 1'b1;
        i_issue_valid = 1'b1;
        i_issue_dest = DST_XREG;
        tick();
        i_flush = 1'b0;
        i_issue_valid = 1'b0;
        sb_q.delete();
        m_tail = 0;
        chk("t6_flush_cnt", o_count, 0);
        issue(DST_XREG);
        chk("t6_count1", o_count, 1);
        result(4'd2, 32'h7, 5'b0, 0);
        chk("t6_late_err", o_err_spurious, 1);
        i_toXreg_ready = 1'b0;
        result(4'd0, 32'hcafe0001, 5'b0, 1);
        chk("t6_pre_xv", o_toXreg_valid, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("t6_rst_xv", o_toXreg_valid, 0);
        chk("t6_rst_data", o_data_toXreg, 0);
        chk("t6_rst_id", o_id_out, 0);
        chk("t6_rst_cnt", o_count, 0);
        chk("t6_rst_err", o_err_spurious, 0);
        chk("t6_rst_rdy", o_issue_ready, 1);
        sb_q.delete();
        tick();
        i_rst_n = 1'b1;
        tick();

        chk("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
